// File: rtl/sd_link_sched_pkg.sv
// Shared definitions for the link scheduler: scheduler state encoding and
// the index-width helper used to size channel numbers.
package sd_link_sched_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } sched_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sd_link_sched_rr_pick.sv
// Combinational round-robin picker: first set request strictly after i_ptr,
// wrapping, found by rotating a doubled request vector and priority-encoding.
module sd_rr_pick #(
  parameter int inputs = 4,
  parameter int cw     = 2
) (
  input  logic [inputs-1:0] i_req,
  input  logic [cw-1:0]     i_ptr,
  output logic [cw-1:0]     o_gnt,
  output logic              o_gnt_vld
);

  localparam logic [cw+1:0] LP_N = (cw+2)'(inputs);

  logic [2*inputs-1:0] w_req2;
  logic [inputs-1:0]   w_rot;
  logic [cw+1:0]       w_start;
  logic [cw+1:0]       w_sum;
  logic [cw-1:0]       w_off;

  always_comb begin
    w_req2    = {i_req, i_req};
    w_start   = {2'b00, i_ptr} + (cw+2)'(1);
    w_rot     = inputs'(w_req2 >> w_start);
    w_off     = '0;
    o_gnt_vld = 1'b0;
    // Descending scan so the lowest rotated offset wins.
    for (int i = inputs - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_gnt_vld = 1'b1;
        w_off     = cw'(i);
      end
    end
    w_sum = w_start + {2'b00, w_off};
    if (w_sum >= LP_N) w_sum = w_sum - LP_N;
    o_gnt = w_sum[cw-1:0];
  end

endmodule

// File: rtl/sd_link_sched.sv
// Round-robin scheduler sharing one srdy/drdy link between several channels,
// with optional per-packet grant locking and a single registered output stage.
module sd_link_sched
  import sd_link_sched_pkg::*;
#(
  parameter int inputs = 4,
  parameter int width  = 10,
  parameter bit lock   = 1'b1,
  parameter int cw     = clog2(inputs)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [inputs-1:0]       c_srdy,
  output logic [inputs-1:0]       c_drdy,
  input  logic [inputs*width-1:0] c_data,
  input  logic [inputs-1:0]       c_eop,
  output logic                    p_srdy,
  input  logic                    p_drdy,
  output logic [width-1:0]        p_data,
  output logic                    p_eop,
  output logic [cw-1:0]           p_chan,
  output logic                    o_dbg_state
);

  // Handshake: a word moves on any edge where srdy and drdy are both high;
  // a source may not wait for drdy before raising srdy.
  sched_state_e     r_state, w_state_nxt;
  logic [cw-1:0]    r_ptr, r_lock_chan, w_pick_gnt, w_gnt;
  logic             w_pick_vld, w_gnt_vld, w_load_ok, w_xfer, w_locked;
  logic             r_p_srdy, r_p_eop;
  logic [width-1:0] r_p_data;
  logic [cw-1:0]    r_p_chan;

  sd_rr_pick #(.inputs(inputs), .cw(cw)) u_pick (
    .i_req     (c_srdy),
    .i_ptr     (r_ptr),
    .o_gnt     (w_pick_gnt),
    .o_gnt_vld (w_pick_vld)
  );

  // Gated by reset so no source sees a grant while the block is held in reset.
  assign w_load_ok = reset & (~r_p_srdy | p_drdy);
  assign w_gnt     = w_locked ? r_lock_chan : w_pick_gnt;
  assign w_gnt_vld = w_locked ? c_srdy[r_lock_chan] : w_pick_vld;
  assign w_xfer    = w_load_ok & w_gnt_vld;

  always_comb begin
    c_drdy        = '0;
    c_drdy[w_gnt] = w_xfer;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (lock && w_xfer && !c_eop[w_gnt]) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (w_xfer && c_eop[w_gnt])          w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_locked    = (r_state == ST_LOCKED);
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p_srdy    <= 1'b0;
      r_p_data    <= '0;
      r_p_eop     <= 1'b0;
      r_p_chan    <= '0;
      r_ptr       <= cw'(inputs - 1);
      r_lock_chan <= '0;
    end else begin
      if (w_xfer) begin
        r_p_srdy <= 1'b1;
        r_p_data <= c_data[w_gnt*width +: width];
        r_p_eop  <= c_eop[w_gnt];
        r_p_chan <= w_gnt;
        r_ptr    <= w_gnt;
      end else if (p_drdy) begin
        r_p_srdy <= 1'b0;
      end
      if (w_xfer && !w_locked) r_lock_chan <= w_gnt;
    end
  end

  assign p_srdy = r_p_srdy;
  assign p_data = r_p_data;
  assign p_eop  = r_p_eop;
  assign p_chan = r_p_chan;

endmodule

// File: tb/tb_sd_link_sched.sv
// Directed bench for sd_link_sched: one lock=0 and one lock=1 instance share
// the channel inputs; sel picks which instance's outputs are observed.
module tb_sd_link_sched;

  localparam int N  = 4;
  localparam int W  = 10;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [N-1:0]   c_srdy, c_eop;
  logic [N*W-1:0] c_data;
  logic           p_drdy;
  logic           sel;

  logic [N-1:0]  a_drdy, b_drdy;
  logic          a_p_srdy, b_p_srdy, a_p_eop, b_p_eop, a_state, b_state;
  logic [W-1:0]  a_p_data, b_p_data;
  logic [CW-1:0] a_p_chan, b_p_chan;

  logic [N-1:0]  w_drdy;
  logic          w_p_srdy, w_p_eop, w_state;
  logic [W-1:0]  w_p_data;
  logic [CW-1:0] w_p_chan;

  assign w_drdy   = sel ? b_drdy   : a_drdy;
  assign w_p_srdy = sel ? b_p_srdy : a_p_srdy;
  assign w_p_eop  = sel ? b_p_eop  : a_p_eop;
  assign w_p_data = sel ? b_p_data : a_p_data;
  assign w_p_chan = sel ? b_p_chan : a_p_chan;
  assign w_state  = sel ? b_state  : a_state;

  sd_link_sched #(.inputs(N), .width(W), .lock(1'b0)) dut_a (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(a_drdy), .c_data(c_data),
    .c_eop(c_eop), .p_srdy(a_p_srdy), .p_drdy(p_drdy), .p_data(a_p_data),
    .p_eop(a_p_eop), .p_chan(a_p_chan), .o_dbg_state(a_state)
  );

  sd_link_sched #(.inputs(N), .width(W), .lock(1'b1)) dut_b (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(b_drdy), .c_data(c_data),
    .c_eop(c_eop), .p_srdy(b_p_srdy), .p_drdy(p_drdy), .p_data(b_p_data),
    .p_eop(b_p_eop), .p_chan(b_p_chan), .o_dbg_state(b_state)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [W:0] exp_q[N][$];
  int src_seq[N];
  int xfer_ch[N];
  int obs_q[$];
  int xfer_cnt;
  logic hold_prev = 1'b0;
  logic [W+CW+1:0] hold_val;

  function automatic logic [W-1:0] enc(input int ch, input int seq);
    return W'(ch * 100 + seq % 100);
  endfunction

  // One link cycle: drive at negedge, observe just after, edge at posedge.
  task automatic step(input logic [N-1:0] srdy, input logic [N-1:0] eop, input logic drdy);
    logic [W:0] exp_w;
    @(negedge clk);
    c_srdy = srdy;
    c_eop  = eop;
    p_drdy = drdy;
    for (int k = 0; k < N; k++) c_data[k*W +: W] = enc(k, src_seq[k]);
    #1;
    n_chk++;
    if ($countones(w_drdy) > 1) begin
      n_bad++; $display("FAIL drdy_onehot got=%b exp=at most one bit", w_drdy);
    end
    if (w_p_srdy && !drdy) begin
      n_chk++;
      if (w_drdy !== '0) begin n_bad++; $display("FAIL drdy_in_stall got=%b exp=0000", w_drdy); end
    end
    if (hold_prev) begin
      n_chk++;
      if ({w_p_srdy, w_p_eop, w_p_chan, w_p_data} !== hold_val) begin
        n_bad++;
        $display("FAIL hold_stable got=%h exp=%h", {w_p_srdy, w_p_eop, w_p_chan, w_p_data}, hold_val);
      end
    end
    hold_prev = w_p_srdy && !drdy;
    hold_val  = {w_p_srdy, w_p_eop, w_p_chan, w_p_data};
    if (w_p_srdy && drdy) begin
      obs_q.push_back(int'(w_p_chan));
      n_chk++;
      if (exp_q[w_p_chan].size() == 0) begin
        n_bad++; $display("FAIL out_word got=chan%0d data=%0d exp=no pending word", w_p_chan, w_p_data);
      end else begin
        exp_w = exp_q[w_p_chan].pop_front();
        if ({w_p_eop, w_p_data} !== exp_w) begin
          n_bad++;
          $display("FAIL out_word chan=%0d got=eop%0b/%0d exp=eop%0b/%0d", w_p_chan, w_p_eop, w_p_data, exp_w[W], exp_w[W-1:0]);
        end
      end
    end
    for (int k = 0; k < N; k++) begin
      if (srdy[k] && w_drdy[k]) begin
        exp_q[k].push_back({eop[k], enc(k, src_seq[k])});
        src_seq[k]++;
        xfer_ch[k]++;
        xfer_cnt++;
      end
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int left;
    for (int i = 0; i < 3; i++) step('0, '0, 1'b1);
    left = 0;
    for (int k = 0; k < N; k++) left += exp_q[k].size();
    n_chk++;
    if (left != 0) begin n_bad++; $display("FAIL drain_leftover got=%0d exp=0", left); end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; c_srdy = '0; c_eop = '0; p_drdy = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < N; k++) begin
      exp_q[k].delete(); src_seq[k] = 0; xfer_ch[k] = 0;
    end
    hold_prev = 1'b0;
    obs_q.delete();
    xfer_cnt = 0;
  endtask

  task automatic test_reset();
    sel = 1'b0; reset = 1'b0; c_srdy = '1; c_eop = '0; p_drdy = 1'b1;
    for (int k = 0; k < N; k++) c_data[k*W +: W] = enc(k, 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_chk += 7;
    if (a_p_srdy !== 1'b0) begin n_bad++; $display("FAIL rst_p_srdy got=%b exp=0", a_p_srdy); end
    if (a_drdy !== '0)     begin n_bad++; $display("FAIL rst_a_drdy got=%b exp=0000", a_drdy); end
    if (b_drdy !== '0)     begin n_bad++; $display("FAIL rst_b_drdy got=%b exp=0000", b_drdy); end
    if (a_p_data !== '0)   begin n_bad++; $display("FAIL rst_p_data got=%0d exp=0", a_p_data); end
    if (a_p_chan !== '0)   begin n_bad++; $display("FAIL rst_p_chan got=%0d exp=0", a_p_chan); end
    if (a_p_eop !== 1'b0)  begin n_bad++; $display("FAIL rst_p_eop got=%b exp=0", a_p_eop); end
    if (b_state !== 1'b0)  begin n_bad++; $display("FAIL rst_state got=%b exp=0", b_state); end
    c_srdy = '0;
    reset  = 1'b1;
    step(4'hf, 4'h0, 1'b1);
    #1;
    n_chk += 3;
    if (w_p_srdy !== 1'b1)       begin n_bad++; $display("FAIL first_srdy got=%b exp=1", w_p_srdy); end
    if (w_p_chan !== 2'd0)       begin n_bad++; $display("FAIL first_chan got=%0d exp=0", w_p_chan); end
    if (w_p_data !== enc(0, 0))  begin n_bad++; $display("FAIL first_data got=%0d exp=%0d", w_p_data, enc(0, 0)); end
    drain();
  endtask

  task automatic test_rotation();
    do_reset();
    sel = 1'b0;
    repeat (16) step(4'hf, 4'h0, 1'b1);
    n_chk++;
    if (xfer_cnt != 16) begin n_bad++; $display("FAIL rot_rate got=%0d exp=16", xfer_cnt); end
    drain();
    n_chk++;
    if (obs_q.size() != 16) begin n_bad++; $display("FAIL rot_count got=%0d exp=16", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] != i % N) begin n_bad++; $display("FAIL rot_order idx=%0d got=%0d exp=%0d", i, obs_q[i], i % N); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] pat;
    pat = 8'h03;
    obs_q.delete();
    xfer_cnt = 0;
    for (int i = 0; i < 40; i++) step(4'hf, 4'h0, pat[i % 8]);
    n_chk++;
    if (xfer_cnt != 10) begin n_bad++; $display("FAIL bp_xfers got=%0d exp=10", xfer_cnt); end
    drain();
    n_chk++;
    if (obs_q.size() != 10) begin n_bad++; $display("FAIL bp_count got=%0d exp=10", obs_q.size()); end
    for (int i = 0; i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] != i % N) begin n_bad++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, obs_q[i], i % N); end
    end
  endtask

  task automatic test_lock_packet();
    int exp_ch[5] = '{1, 1, 1, 2, 2};
    do_reset();
    sel = 1'b1;
    step(4'b0010, 4'b0000, 1'b1);
    #1;
    n_chk++;
    if (w_state !== 1'b1) begin n_bad++; $display("FAIL lock_enter got=%b exp=1", w_state); end
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b1111, 4'b0010, 1'b1);
    step(4'b1111, 4'b0000, 1'b1);
    step(4'b0100, 4'b0100, 1'b1);
    drain();
    n_chk += 2;
    if (w_state !== 1'b0)   begin n_bad++; $display("FAIL lock_exit got=%b exp=0", w_state); end
    if (obs_q.size() != 5) begin n_bad++; $display("FAIL pkt_count got=%0d exp=5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] != exp_ch[i]) begin n_bad++; $display("FAIL pkt_order idx=%0d got=%0d exp=%0d", i, obs_q[i], exp_ch[i]); end
    end
  endtask

  task automatic test_lock_stall();
    int exp_ch[6] = '{2, 2, 3, 2, 2, 0};
    obs_q.delete();
    sel = 1'b1;
    step(4'b0100, 4'b0000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'b0001, 4'b0000, 1'b1);
      #1;
      n_chk++;
      if (w_drdy !== '0) begin n_bad++; $display("FAIL stall_drdy cyc=%0d got=%b exp=0000", i, w_drdy); end
    end
    n_chk++;
    if (w_state !== 1'b1) begin n_bad++; $display("FAIL stall_state got=%b exp=1", w_state); end
    step(4'b1101, 4'b0100, 1'b1);
    step(4'b1001, 4'b1000, 1'b1);
    step(4'b0100, 4'b0000, 1'b1);
    step(4'b0101, 4'b0100, 1'b1);
    step(4'b0001, 4'b0001, 1'b1);
    drain();
    n_chk++;
    if (obs_q.size() != 6) begin n_bad++; $display("FAIL stall_count got=%0d exp=6", obs_q.size()); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_chk++;
      if (obs_q[i] != exp_ch[i]) begin n_bad++; $display("FAIL stall_order idx=%0d got=%0d exp=%0d", i, obs_q[i], exp_ch[i]); end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] srdy, eop;
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      for (int k = 0; k < N; k++) begin
        srdy[k] = ($urandom_range(0, 99) < 85);
        eop[k]  = ($urandom_range(0, 3) == 0);
      end
      step(srdy, eop, $urandom_range(0, 19) != 0);
      if (obs_q.size() > 64) obs_q.delete();
    end
    drain();
    for (int k = 0; k < N; k++) begin
      n_chk++;
      if (xfer_ch[k] < 1000) begin n_bad++; $display("FAIL rand_words chan=%0d got=%0d exp>=1000", k, xfer_ch[k]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    xfer_cnt = 0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_lock_packet();
    test_lock_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
